// File: rtl/nrs_run_scheduler.sv
// nrs_run_scheduler
// Walks the NRS runs of one radio frame (two NRS symbols per slot, l=5 and
// l=6, 20 slots). For each run it works out c_init, starts the Gold
// generator, waits for it to finish and then advances the receive-side slot
// counter. The runs of the NPSS subframe are not issued. A watchdog catches a
// generator that never answers.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-low reset
//   frame_start  pulse; starts a frame sequence when idle
//   abort        synchronous return to idle
//   ncell_id     cell ID (0..503), latched when a frame is accepted
//   gold_done    pulse from the generator: the current run is finished
//   cinit        c_init of the current run
//   cinit_valid  start pulse to the Gold generator
//   cinit_run    pulse to the slot counter, one per completed run
//   slot         ns of the current run
//   sym_l        OFDM symbol l of the current run (5 or 6)
//   busy         sequencer is not idle
//   frame_done   pulse with the cinit_run of the last run
//   err_timeout  sticky watchdog error
module nrs_run_scheduler #(
   parameter int SKIP_SF      = 5,
   parameter int DONE_TIMEOUT = 1023,
   parameter int NUM_RUNS     = 40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_start,
   input  logic        abort,
   input  logic [8:0]  ncell_id,
   input  logic        gold_done,
   output logic [30:0] cinit,
   output logic        cinit_valid,
   output logic        cinit_run,
   output logic [4:0]  slot,
   output logic [2:0]  sym_l,
   output logic        busy,
   output logic        frame_done,
   output logic        err_timeout
);

   localparam int RUN_W = $clog2(NUM_RUNS + 8);
   localparam int WD_W  = $clog2(DONE_TIMEOUT + 2);
   localparam logic [WD_W-1:0]  WD_LAST      = WD_W'((DONE_TIMEOUT == 0) ? 0 : DONE_TIMEOUT - 1);
   localparam logic [RUN_W-1:0] RUN_LAST     = RUN_W'(NUM_RUNS - 1);
   localparam logic [RUN_W-1:0] RUN_PRE_SKIP = RUN_W'(4 * SKIP_SF - 1);
   localparam logic [RUN_W-1:0] RUN_END      = RUN_W'(NUM_RUNS);

   typedef enum logic [2:0] {IDLE, CALC1, CALC2, ISSUE, WAIT, ADV} state_t;

   state_t             state, state_nxt;
   logic [RUN_W-1:0]   run, run_nxt, run_inc;
   logic               adv_last;
   logic               load_pos;
   logic               wd_expire;
   logic               accept;
   logic [8:0]         id_q;
   logic [7:0]         t_q;
   logic [WD_W-1:0]    wd_cnt;

   // t = 7*(ns+1) + l + 1, at most 147
   function automatic logic [7:0] calc_t(input logic [4:0] ns, input logic [2:0] l);
      return ({3'b000, ns} + 8'd1) * 8'd7 + {5'b00000, l} + 8'd1;
   endfunction

   // c_init = (t*(2*ID+1)) << 10 + 2*ID + 1, at most 151582703 (fits 28 bits)
   function automatic logic [30:0] calc_cinit(input logic [7:0] t, input logic [8:0] id);
      logic [9:0]  id2p1;
      logic [17:0] prod;
      id2p1 = {id, 1'b1};
      prod  = {10'd0, t} * {8'd0, id2p1};
      return {3'b000, prod, 10'd0} + {21'd0, id2p1};
   endfunction

   // The NPSS subframe's four runs are jumped over by stepping 5 instead of 1.
   // A skip that would run past the end of the frame ends the frame instead.
   always_comb begin
      run_inc  = (run == RUN_PRE_SKIP) ? run + RUN_W'(5) : run + RUN_W'(1);
      adv_last = (run == RUN_LAST) || (run_inc >= RUN_END);
   end

   assign accept = (state == IDLE) && frame_start && !abort;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         run   <= '0;
      end else begin
         state <= state_nxt;
         run   <= run_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      run_nxt   = run;
      load_pos  = 1'b0;
      wd_expire = 1'b0;
      case (state)
         IDLE: begin
            if (frame_start) begin
               state_nxt = CALC1;
               run_nxt   = '0;
               load_pos  = 1'b1;
            end
         end
         CALC1: state_nxt = CALC2;
         CALC2: state_nxt = ISSUE;
         ISSUE: state_nxt = WAIT;
         WAIT: begin
            if (gold_done) begin
               state_nxt = ADV;
            end else if ((DONE_TIMEOUT != 0) && (wd_cnt == WD_LAST)) begin
               state_nxt = IDLE;
               wd_expire = 1'b1;
            end
         end
         ADV: begin
            if (adv_last) begin
               state_nxt = IDLE;
               run_nxt   = '0;
            end else begin
               state_nxt = CALC1;
               run_nxt   = run_inc;
               load_pos  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (abort) begin
         state_nxt = IDLE;
         run_nxt   = '0;
         load_pos  = 1'b0;
         wd_expire = 1'b0;
      end
   end

   // Strobes decode straight from the state so an abort drops them on the
   // same edge that returns the FSM to IDLE.
   assign cinit_valid = (state == ISSUE);
   assign cinit_run   = (state == ADV);
   assign frame_done  = (state == ADV) && adv_last;
   assign busy        = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         id_q        <= '0;
         t_q         <= '0;
         cinit       <= '0;
         slot        <= '0;
         sym_l       <= '0;
         wd_cnt      <= '0;
         err_timeout <= 1'b0;
      end else begin
         if (accept) begin
            id_q <= ncell_id;
         end
         if (load_pos) begin
            slot  <= 5'(run_nxt >> 1);
            sym_l <= run_nxt[0] ? 3'd6 : 3'd5;
         end
         // cinit pipeline: CALC1 forms t, CALC2 forms c_init
         if ((state == CALC1) && !abort) begin
            t_q <= calc_t(slot, sym_l);
         end
         if ((state == CALC2) && !abort) begin
            cinit <= calc_cinit(t_q, id_q);
         end
         wd_cnt <= (state == WAIT) ? wd_cnt + WD_W'(1) : '0;
         if (wd_expire) begin
            err_timeout <= 1'b1;
         end else if (accept) begin
            err_timeout <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_nrs_run_scheduler.sv
// Directed bench for nrs_run_scheduler: first runs, full frame with NPSS
// skip, watchdog, abort, ignored inputs and asynchronous reset.
module tb_nrs_run_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        frame_start = 1'b0;
   logic        abort = 1'b0;
   logic [8:0]  ncell_id = '0;
   logic        gold_done = 1'b0;
   logic [30:0] cinit;
   logic        cinit_valid;
   logic        cinit_run;
   logic [4:0]  slot;
   logic [2:0]  sym_l;
   logic        busy;
   logic        frame_done;
   logic        err_timeout;

   int checks = 0;
   int failures = 0;

   nrs_run_scheduler #(.SKIP_SF(5), .DONE_TIMEOUT(16), .NUM_RUNS(40)) dut (
      .clk(clk), .rst(rst), .frame_start(frame_start), .abort(abort),
      .ncell_id(ncell_id), .gold_done(gold_done), .cinit(cinit),
      .cinit_valid(cinit_valid), .cinit_run(cinit_run), .slot(slot),
      .sym_l(sym_l), .busy(busy), .frame_done(frame_done),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input logic [8:0] id);
      ncell_id    = id;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      checks++;
      if ({cinit_valid, cinit_run, busy, frame_done, err_timeout} !== 5'b0) begin
         failures++;
         $display("FAIL reset_strobes: got %b expected 00000",
                  {cinit_valid, cinit_run, busy, frame_done, err_timeout});
      end
      checks++;
      if ({cinit, slot, sym_l} !== '0) begin
         failures++;
         $display("FAIL reset_data: cinit=%0d slot=%0d sym_l=%0d expected all 0", cinit, slot, sym_l);
      end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_first_runs();
      start_frame(9'd0);
      tick();
      tick();
      checks++;
      if (cinit_valid !== 1'b1 || cinit !== 31'd13313 || slot !== 5'd0 || sym_l !== 3'd5) begin
         failures++;
         $display("FAIL first_issue: valid=%b cinit=%0d slot=%0d l=%0d expected 1 13313 0 5",
                  cinit_valid, cinit, slot, sym_l);
      end
      gold_done = 1'b1;               // coincides with cinit_valid: must be ignored
      tick();
      gold_done = 1'b0;
      tick();
      tick();
      checks++;
      if (cinit_run !== 1'b0 || busy !== 1'b1 || cinit !== 31'd13313) begin
         failures++;
         $display("FAIL early_done_ignored: run=%b busy=%b cinit=%0d expected 0 1 13313",
                  cinit_run, busy, cinit);
      end
      gold_done = 1'b1;
      tick();
      gold_done = 1'b0;
      checks++;
      if (cinit_run !== 1'b1 || frame_done !== 1'b0) begin
         failures++;
         $display("FAIL first_adv: cinit_run=%b frame_done=%b expected 1 0", cinit_run, frame_done);
      end
      tick();
      tick();
      tick();
      checks++;
      if (cinit_valid !== 1'b1 || cinit !== 31'd14337 || slot !== 5'd0 || sym_l !== 3'd6) begin
         failures++;
         $display("FAIL second_issue: valid=%b cinit=%0d slot=%0d l=%0d expected 1 14337 0 6",
                  cinit_valid, cinit, slot, sym_l);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   // Full frame; also pulses frame_start in ADV and gold_done in CALC1.
   task automatic test_full_frame();
      int nvalid = 0, nrun = 0, nfd = 0, gd = 0, ext = 0;
      int pslot = -1, psym = -1;
      bit fs_flag = 0, bad_slot = 0, skip_ok = 0, fd_seen = 0, fd_with_run = 0;
      logic [30:0] last_cinit = '0;
      logic [4:0]  last_slot = '0;
      logic [2:0]  last_sym = '0;
      start_frame(9'd503);
      for (int cyc = 0; cyc < 3000 && !fd_seen; cyc++) begin
         gold_done   = 1'b0;
         frame_start = fs_flag;
         fs_flag     = 0;
         if (gd > 0) begin
            gd--;
            if (gd == 0) gold_done = 1'b1;
         end
         if (ext > 0) begin
            ext--;
            if (ext == 0) gold_done = 1'b1;
         end
         tick();
         if (cinit_valid) begin
            nvalid++;
            if (slot == 5'd10 || slot == 5'd11) bad_slot = 1;
            if (slot == 5'd12 && sym_l == 3'd5) skip_ok = (pslot == 9 && psym == 6);
            pslot = slot;
            psym = sym_l;
            last_cinit = cinit;
            last_slot = slot;
            last_sym = sym_l;
            gd = 4;
         end
         if (cinit_run) begin
            nrun++;
            if (!frame_done) begin
               fs_flag = 1;
               ext = 2;
            end
         end
         if (frame_done) begin
            nfd++;
            fd_seen = 1;
            fd_with_run = cinit_run;
         end
      end
      gold_done = 1'b0;
      frame_start = 1'b0;
      checks++;
      if (!fd_seen) begin
         failures++;
         $display("FAIL frame_done_seen: got 0 expected 1 within cycle budget");
      end
      checks++;
      if (nvalid != 36 || nrun != 36) begin
         failures++;
         $display("FAIL run_counts: valid=%0d run=%0d expected 36 36", nvalid, nrun);
      end
      checks++;
      if (last_slot !== 5'd19 || last_sym !== 3'd6 || last_cinit !== 31'd151582703) begin
         failures++;
         $display("FAIL last_run: slot=%0d l=%0d cinit=%0d expected 19 6 151582703",
                  last_slot, last_sym, last_cinit);
      end
      checks++;
      if (fd_with_run !== 1'b1 || nfd != 1) begin
         failures++;
         $display("FAIL frame_done_align: with_run=%b count=%0d expected 1 1", fd_with_run, nfd);
      end
      checks++;
      if (bad_slot || !skip_ok) begin
         failures++;
         $display("FAIL npss_skip: bad_slot=%0d skip_ok=%0d expected 0 1", bad_slot, skip_ok);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || cinit_valid !== 1'b0) begin
         failures++;
         $display("FAIL frame_idle: busy=%b valid=%b expected 0 0", busy, cinit_valid);
      end
   endtask

   task automatic test_timeout();
      bit saw_run = 0;
      start_frame(9'd1);
      tick();
      tick();
      checks++;
      if (cinit_valid !== 1'b1 || cinit !== 31'd39939) begin
         failures++;
         $display("FAIL id1_issue: valid=%b cinit=%0d expected 1 39939", cinit_valid, cinit);
      end
      for (int i = 0; i < 16; i++) begin
         tick();
         if (cinit_run) saw_run = 1;
      end
      checks++;
      if (err_timeout !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL wd_before: err=%b busy=%b expected 0 1", err_timeout, busy);
      end
      tick();
      if (cinit_run) saw_run = 1;
      checks++;
      if (err_timeout !== 1'b1 || busy !== 1'b0 || saw_run) begin
         failures++;
         $display("FAIL wd_expire: err=%b busy=%b saw_run=%0d expected 1 0 0",
                  err_timeout, busy, saw_run);
      end
      start_frame(9'd1);
      checks++;
      if (err_timeout !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL wd_clear: err=%b busy=%b expected 0 1", err_timeout, busy);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic test_abort();
      int nvalid = 0, gd = 0;
      bit saw = 0;
      start_frame(9'd0);
      for (int cyc = 0; cyc < 500 && nvalid < 8; cyc++) begin
         gold_done = 1'b0;
         if (gd > 0) begin
            gd--;
            if (gd == 0) gold_done = 1'b1;
         end
         tick();
         if (cinit_valid) begin
            nvalid++;
            gd = 4;
         end
      end
      gold_done = 1'b0;
      checks++;
      if (nvalid != 8) begin
         failures++;
         $display("FAIL abort_reach_run7: valid count=%0d expected 8", nvalid);
      end
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || cinit_run !== 1'b0 || frame_done !== 1'b0) begin
         failures++;
         $display("FAIL abort_idle: busy=%b run=%b fd=%b expected 0 0 0", busy, cinit_run, frame_done);
      end
      checks++;
      if (slot !== 5'd3 || sym_l !== 3'd6 || cinit !== 31'd35841) begin
         failures++;
         $display("FAIL abort_hold: slot=%0d l=%0d cinit=%0d expected 3 6 35841", slot, sym_l, cinit);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         if (cinit_run || frame_done || busy) saw = 1;
      end
      checks++;
      if (saw) begin
         failures++;
         $display("FAIL abort_quiet: got activity=1 expected 0");
      end
      start_frame(9'd0);
      tick();
      tick();
      checks++;
      if (cinit_valid !== 1'b1 || slot !== 5'd0 || sym_l !== 3'd5) begin
         failures++;
         $display("FAIL abort_restart: valid=%b slot=%0d l=%0d expected 1 0 5", cinit_valid, slot, sym_l);
      end
   endtask

   task automatic test_async_reset();
      tick();                          // now in WAIT of run 0
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({cinit_valid, cinit_run, busy, frame_done, err_timeout} !== 5'b0 ||
          {cinit, slot, sym_l} !== '0) begin
         failures++;
         $display("FAIL async_reset: busy=%b cinit=%0d slot=%0d l=%0d expected all 0",
                  busy, cinit, slot, sym_l);
      end
      #1;
      rst = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_idle: busy=%b expected 0", busy);
      end
   endtask

   initial begin
      test_reset();
      test_first_runs();
      test_full_frame();
      test_timeout();
      test_abort();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
